baccarat_sequencer: RTL and testbench
=====================================

// Module: baccarat_sequencer
// PURPOSE
//  Control FSM for the baccarat card datapath: issues one-hot load strobes
//  (player/dealer cards 1-3) in the dealing order.
//  Applies the player and banker third-card rules to the datapath's pscore/dscore/pcard3 feedback.
//  Drives the win lights once the hand is complete.
//  Sits between the board top level and the datapath; shares its slow_clock.
// PARAMETERS
//  PDRAW_MAX    5  player (and standing-player banker) draws when score <= PDRAW_MAX
//  NATURAL_MIN  8  two-card score >= NATURAL_MIN on either hand ends the game (natural)
// PORTS
//  slow_clock        in   1  sole clock, all state updates on rising edge
//  reset             in   1  asynchronous, active-high; clears FSM immediately
//  pscore_in         in   4  player score from datapath (0..9)
//  dscore_in         in   4  dealer score from datapath (0..9)
//  pcard3_in         in   4  player third card code from datapath (0 none, 1..13)
//  load_pcard1..3    out  1  each: load strobe to datapath player card register
//  load_dcard1..3    out  1  each: load strobe to datapath dealer card register
//  player_win_light  out  1  player wins (both lights on = tie)
//  dealer_win_light  out  1  dealer wins
// BEHAVIOUR
//  States (4-bit, encoding fixed): P1=0 D1=1 P2=2 D2=3 EVAL=4 P3=5 BCHK=6 D3=7 DONE=8.
//  Reset value: state=P1. While reset=1, all load_* and win lights = 0 (async, gated).
//    After release, first state is P1.
//  Moore outputs decoded from state only; exactly one load_* high in P1,D1,P2,D2,P3,D3; none elsewhere.
//    Each load_* lasts exactly one cycle; the datapath captures the card on the edge leaving that state.
//  Sequence: P1->D1->P2->D2->EVAL, one state per edge.
//    The scores seen in EVAL include all four cards.
//  EVAL:
//    pscore>=NATURAL_MIN or dscore>=NATURAL_MIN -> DONE.
//    Else pscore<=PDRAW_MAX -> P3.
//    Else (player stands) dscore<=PDRAW_MAX -> D3, else DONE.
//  P3 -> BCHK unconditionally; BCHK sees the updated pcard3_in.
//  BCHK: v = (pcard3_in>=10) ? 0 : pcard3_in; banker draws (->D3) iff:
//    dscore 0..2 always; 3: v!=8; 4: v in 2..7; 5: v in 4..7; 6: v in 6..7;
//    otherwise -> DONE.
//  D3 -> DONE.
//  DONE is absorbing until reset; outputs are combinational from the held scores:
//    player_win_light = (pscore>=dscore); dealer_win_light = (dscore>=pscore).
//    Win lights are 0 in every state other than DONE.
//  Score inputs are unsigned 4-bit; values 10..15 are illegal.
//    Compare as unsigned; no saturation is required.
//  Reset asserted in any state returns to P1; a partially dealt hand is abandoned.
//    The datapath is cleared by the same reset.
//  Illegal state codes (9..15) -> P1 on next edge, no load asserted.
// CONFIGURATION
//  SEQ_STEP_EN defined:
//    Adds input step (1 bit, after reset in port list).
//    The FSM advances only on edges where step=1.
//    Each load_* = (state match) & step, so a held state never reloads a card.
//    Win lights are unaffected by step.
//  SEQ_STEP_EN undefined:
//    No step port; behaves as step=1 every cycle.
// TESTING
//  1) reset pulse, then 4 edges -> load_pcard1,dcard1,pcard2,dcard2 high one cycle each, in order;
//     all others 0.
//  2) in EVAL drive pscore=8,dscore=3 -> next edge DONE, no load_pcard3/dcard3;
//     player_win=1, dealer_win=0.
//  3) EVAL pscore=4,dscore=3 -> P3 (load_pcard3=1); then pcard3_in=8 -> BCHK->DONE, no load_dcard3;
//     player_win=1.
//  4) EVAL pscore=6,dscore=5 -> D3 (load_dcard3=1) -> DONE; dscore=6 -> both lights=1 (tie).
//  5) EVAL pscore=2,dscore=6, pcard3_in=12 (v=0) -> BCHK->DONE;
//     then reset mid-DONE -> lights 0 immediately; after release, state=P1.
//  6) [SEQ_STEP_EN] hold step=0 for 3 edges in D1 -> state stays D1, load_dcard1=0;
//     step=1 -> one load_dcard1 pulse.

Source files
------------

// File: rtl/baccarat_sequencer.sv
// rtl/baccarat_sequencer.sv - baccarat dealing/third-card control FSM (optional SEQ_STEP_EN step gating)
module baccarat_sequencer #(
    parameter int PDRAW_MAX   = 5,
    parameter int NATURAL_MIN = 8
) (
    input  logic       slow_clock,
    input  logic       reset,
`ifdef SEQ_STEP_EN
    input  logic       step,
`endif
    input  logic [3:0] pscore_in,
    input  logic [3:0] dscore_in,
    input  logic [3:0] pcard3_in,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light
);

    // State encoding is fixed; the datapath side and debug tooling rely on it.
    localparam logic [3:0] S_P1   = 4'd0;
    localparam logic [3:0] S_D1   = 4'd1;
    localparam logic [3:0] S_P2   = 4'd2;
    localparam logic [3:0] S_D2   = 4'd3;
    localparam logic [3:0] S_EVAL = 4'd4;
    localparam logic [3:0] S_P3   = 4'd5;
    localparam logic [3:0] S_BCHK = 4'd6;
    localparam logic [3:0] S_D3   = 4'd7;
    localparam logic [3:0] S_DONE = 4'd8;

    localparam logic [3:0] DRAW_MAX = PDRAW_MAX[3:0];
    localparam logic [3:0] NAT_MIN  = NATURAL_MIN[3:0];

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       adv;
    logic       natural_hand;
    logic       player_draws;
    logic       dealer_stand_draws;
    logic       banker_draws;
    logic [3:0] pcard3_val;

    // Advance qualifier: without the step feature the FSM moves every edge.
`ifdef SEQ_STEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    // Face cards (10, J, Q, K) count as zero toward the banker decision.
    assign pcard3_val = (pcard3_in >= 4'd10) ? 4'd0 : pcard3_in;

    // EVAL decisions on the four-card scores.
    assign natural_hand       = (pscore_in >= NAT_MIN) || (dscore_in >= NAT_MIN);
    assign player_draws       = (pscore_in <= DRAW_MAX);
    assign dealer_stand_draws = (dscore_in <= DRAW_MAX);

    // Banker third-card tableau, keyed on banker score and player third-card value.
    always_comb begin
        banker_draws = 1'b0;
        case (dscore_in)
            4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
            4'd3:             banker_draws = (pcard3_val != 4'd8);
            4'd4:             banker_draws = (pcard3_val >= 4'd2) && (pcard3_val <= 4'd7);
            4'd5:             banker_draws = (pcard3_val >= 4'd4) && (pcard3_val <= 4'd7);
            4'd6:             banker_draws = (pcard3_val >= 4'd6) && (pcard3_val <= 4'd7);
            default:          banker_draws = 1'b0;
        endcase
    end

    // Next-state logic; illegal codes recover to P1 regardless of step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_P1:   if (adv) state_d = S_D1;
            S_D1:   if (adv) state_d = S_P2;
            S_P2:   if (adv) state_d = S_D2;
            S_D2:   if (adv) state_d = S_EVAL;
            S_EVAL: begin
                if (adv) begin
                    if (natural_hand) begin
                        state_d = S_DONE;
                    end else if (player_draws) begin
                        state_d = S_P3;
                    end else if (dealer_stand_draws) begin
                        state_d = S_D3;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_P3:   if (adv) state_d = S_BCHK;
            S_BCHK: begin
                if (adv) begin
                    state_d = banker_draws ? S_D3 : S_DONE;
                end
            end
            S_D3:   if (adv) state_d = S_DONE;
            S_DONE: state_d = S_DONE;
            default: state_d = S_P1;
        endcase
    end

    // State register; reset abandons any partially dealt hand.
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            state_q <= S_P1;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore load strobes, gated so a held (stepped-off) state never reloads and reset blanks them.
    always_comb begin
        load_pcard1 = 1'b0;
        load_pcard2 = 1'b0;
        load_pcard3 = 1'b0;
        load_dcard1 = 1'b0;
        load_dcard2 = 1'b0;
        load_dcard3 = 1'b0;
        if (!reset && adv) begin
            case (state_q)
                S_P1:    load_pcard1 = 1'b1;
                S_D1:    load_dcard1 = 1'b1;
                S_P2:    load_pcard2 = 1'b1;
                S_D2:    load_dcard2 = 1'b1;
                S_P3:    load_pcard3 = 1'b1;
                S_D3:    load_dcard3 = 1'b1;
                default: ;
            endcase
        end
    end

    // Win lights follow the held scores once the hand is complete; both on means a tie.
    always_comb begin
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
        if (!reset && (state_q == S_DONE)) begin
            player_win_light = (pscore_in >= dscore_in);
            dealer_win_light = (dscore_in >= pscore_in);
        end
    end

endmodule

// File: tb/tb_baccarat_sequencer.sv
// tb/tb_baccarat_sequencer.sv - randomized hands against a game-level model of the sequencer
module tb_baccarat_sequencer;

    localparam int PDRAW = 5;
    localparam int NAT   = 8;

    localparam logic [7:0] V_P1 = 8'b1000_0000;
    localparam logic [7:0] V_P2 = 8'b0100_0000;
    localparam logic [7:0] V_P3 = 8'b0010_0000;
    localparam logic [7:0] V_D1 = 8'b0001_0000;
    localparam logic [7:0] V_D2 = 8'b0000_1000;
    localparam logic [7:0] V_D3 = 8'b0000_0100;

    typedef struct {
        logic [3:0] ps;
        logic [3:0] ds;
        logic [3:0] pc;
        logic       st;
        logic [7:0] ex;
    } cyc_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       step = 1'b1;
    logic [3:0] pscore_in = 4'd0;
    logic [3:0] dscore_in = 4'd0;
    logic [3:0] pcard3_in = 4'd0;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light;

    cyc_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    baccarat_sequencer dut (
        .slow_clock      (clk),
        .reset           (reset),
`ifdef SEQ_STEP_EN
        .step            (step),
`endif
        .pscore_in       (pscore_in),
        .dscore_in       (dscore_in),
        .pcard3_in       (pcard3_in),
        .load_pcard1     (load_pcard1),
        .load_pcard2     (load_pcard2),
        .load_pcard3     (load_pcard3),
        .load_dcard1     (load_dcard1),
        .load_dcard2     (load_dcard2),
        .load_dcard3     (load_dcard3),
        .player_win_light(player_win_light),
        .dealer_win_light(dealer_win_light)
    );

    wire [7:0] out_vec = {load_pcard1, load_pcard2, load_pcard3, load_dcard1,
                          load_dcard2, load_dcard3, player_win_light, dealer_win_light};

    task automatic check(input string name, input int idx, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s idx %0d: got %b want %b", name, idx, got, want);
        end
    endtask

    // Banker tableau as per-score bitmasks over the player's third-card value.
    function automatic bit banker_rule(input int d, input int v);
        logic [9:0] mask;
        case (d)
            0, 1, 2: mask = 10'b11_1111_1111;
            3:       mask = 10'b10_1111_1111;
            4:       mask = 10'b00_1111_1100;
            5:       mask = 10'b00_1111_0000;
            6:       mask = 10'b00_1100_0000;
            default: mask = 10'b0;
        endcase
        return mask[v];
    endfunction

    task automatic push(input int ps, input int ds, input int pc, input logic st, input logic [7:0] ex);
        cyc_t c;
        c.ps = 4'(ps);
        c.ds = 4'(ds);
        c.pc = 4'(pc);
        c.st = st;
        c.ex = ex;
        q.push_back(c);
    endtask

    function automatic int rnd9();
        return int'($urandom_range(9, 0));
    endfunction

    // Play one hand by the game rules: p2/d2 two-card scores, pc player third card code,
    // p3/d3 the datapath scores after each third card is absorbed.
    task automatic build(input int p2, input int d2, input int pc, input int p3, input int d3,
                         input int stall, output logic [3:0] summary);
        int  pf, df, v;
        bit  dp, dd, pw, dw;
        q.delete();
        pf = p2;
        df = d2;
        dp = 0;
        dd = 0;
        push(rnd9(), rnd9(), 0, 1'b1, V_P1);
        for (int i = 0; i < stall; i++) push(rnd9(), rnd9(), 0, 1'b0, 8'h00);
        push(rnd9(), rnd9(), 0, 1'b1, V_D1);
        push(rnd9(), rnd9(), 0, 1'b1, V_P2);
        push(rnd9(), rnd9(), 0, 1'b1, V_D2);
        push(p2, d2, 0, 1'b1, 8'h00);
        if (p2 >= NAT || d2 >= NAT) begin
            // natural: hand over
        end else if (p2 <= PDRAW) begin
            dp = 1;
            push(p2, d2, 0, 1'b1, V_P3);
            v = (pc >= 10) ? 0 : pc;
            pf = p3;
            push(pf, d2, pc, 1'b1, 8'h00);
            if (banker_rule(d2, v)) begin
                dd = 1;
                push(pf, d2, pc, 1'b1, V_D3);
                df = d3;
            end
        end else if (d2 <= PDRAW) begin
            dd = 1;
            push(p2, d2, 0, 1'b1, V_D3);
            df = d3;
        end
        pw = (pf >= df);
        dw = (df >= pf);
        for (int i = 0; i < 3; i++) push(pf, df, dp ? pc : 0, 1'b1, {6'b0, pw, dw});
        summary = {dp, dd, pw, dw};
    endtask

    task automatic apply(input cyc_t c);
        pscore_in = c.ps;
        dscore_in = c.ds;
        pcard3_in = c.pc;
`ifdef SEQ_STEP_EN
        step = c.st;
`endif
    endtask

    // Reset in the middle of the previous hand's DONE, then play the modelled hand cycle by cycle.
    task automatic run_hand(input string name);
        @(posedge clk);
        #1;
        reset = 1'b1;
        pscore_in = 4'(rnd9());
        dscore_in = 4'(rnd9());
        @(negedge clk);
        check({name, "_reset"}, -1, out_vec, 8'h00);
        @(posedge clk);
        #1;
        apply(q[0]);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check(name, 0, out_vec, q[0].ex);
        for (int i = 1; i < q.size(); i++) begin
            @(posedge clk);
            #1;
            apply(q[i]);
            @(negedge clk);
            check(name, i, out_vec, q[i].ex);
        end
    endtask

    initial begin
        logic [3:0] sm;
        int p2, d2, pc, p3, d3;

        // Directed hands with hand-derived outcomes {player drew, banker drew, pwin, dwin}.
        build(8, 3, 0, 8, 3, 0, sm);
        check("pin_natural", 0, {4'b0, sm}, 8'b0000_0010);
        run_hand("natural");

        build(4, 3, 8, 4, 3, 0, sm);
        check("pin_p3_bstand", 0, {4'b0, sm}, 8'b0000_1010);
        run_hand("p3_bstand");

        build(6, 5, 0, 6, 6, 0, sm);
        check("pin_pstand_d3_tie", 0, {4'b0, sm}, 8'b0000_0111);
        run_hand("pstand_d3_tie");

        build(2, 6, 12, 2, 6, 0, sm);
        check("pin_face_card", 0, {4'b0, sm}, 8'b0000_1001);
        run_hand("face_card");

        build(3, 3, 7, 0, 9, 0, sm);
        check("pin_b3_draw", 0, {4'b0, sm}, 8'b0000_1101);
        run_hand("b3_draw");

`ifdef SEQ_STEP_EN
        build(9, 9, 0, 9, 9, 3, sm);
        run_hand("step_hold");
`endif

        for (int h = 0; h < 40; h++) begin
            p2 = rnd9();
            d2 = rnd9();
            pc = int'($urandom_range(13, 1));
            p3 = rnd9();
            d3 = rnd9();
            build(p2, d2, pc, p3, d3, 0, sm);
            run_hand("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
